key_expand128: RTL

Sequential AES-128 key-expansion engine producing the eleven 128-bit round keys from a cipher key, one 32-bit word per cycle. Sits directly upstream of the existing four-byte SubWord stage. It forms RotWord of the last word, feeds it through one SubWord instance, and folds in Rcon. Round keys are handed downstream (AddRoundKey / cipher round logic) over a valid/ready handshake.

---
 rtl/key_expand128.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/key_expand128.sv
// rtl/key_expand128.sv - sequential AES-128 key expansion, one 32-bit word per cycle
//
// Purpose: produces the eleven AES-128 round keys from a cipher key. Each round
// key is presented downstream over rk_valid/rk_ready. The next round key is then
// built in place over four GEN cycles through a single four-byte SubWord stage.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   request an expansion (accepted only when idle)
//   key_in     in   128-bit cipher key, sampled in the accepting cycle
//   rk_ready   in   downstream accepts round_key this cycle
//   rk_valid   out  round_key / round_idx valid
//   round_key  out  current round key, w[4r] in [127:96]
//   round_idx  out  round number of round_key (0..10)
//   busy       out  high from accept until the final handshake
//   done       out  one-cycle pulse after the last round key is taken
module key_expand128 #(
  parameter int BYTE   = 8,
  parameter int DWORD  = 32,
  parameter int LENGTH = 128,
  parameter int ROUNDS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LENGTH-1:0] key_in,
  input  logic              rk_ready,
  output logic              rk_valid,
  output logic [LENGTH-1:0] round_key,
  output logic [3:0]        round_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_GEN} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254, which maps 0 to 0) followed by
  // the AES affine transform; avoids carrying a 256-entry table.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  state_e           state_q, state_d;
  logic [DWORD-1:0] rk0_q, rk1_q, rk2_q, rk3_q;
  logic [DWORD-1:0] rk0_d, rk1_d, rk2_d, rk3_d;
  logic [7:0]       rcon_q, rcon_d;
  logic [1:0]       j_q, j_d;
  logic [3:0]       round_q, round_d;
  logic             done_q, done_d;

  logic [DWORD-1:0] rot_w;
  logic [DWORD-1:0] sub_w;

  // RotWord of the last word of the previous round: byte a moves to the LSBs.
  assign rot_w = {rk3_q[DWORD-BYTE-1:0], rk3_q[DWORD-1 -: BYTE]};

  for (genvar b = 0; b < DWORD / BYTE; b++) begin : g_sub_word
    assign sub_w[b*BYTE +: BYTE] = sbox(rot_w[b*BYTE +: BYTE]);
  end

  always_comb begin
    state_d = state_q;
    rk0_d   = rk0_q;
    rk1_d   = rk1_q;
    rk2_d   = rk2_q;
    rk3_d   = rk3_q;
    rcon_d  = rcon_q;
    j_d     = j_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          {rk0_d, rk1_d, rk2_d, rk3_d} = key_in;
          round_d = 4'd0;
          rcon_d  = 8'h01;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (rk_ready) begin
          if (round_q == 4'(ROUNDS)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_GEN;
            j_d     = 2'd0;
          end
        end
      end
      S_GEN: begin
        // Words update in place, so each step reads the word written the
        // cycle before; rk3 is untouched until the last step.
        case (j_q)
          2'd0: rk0_d = rk0_q ^ sub_w ^ {rcon_q, {(DWORD-BYTE){1'b0}}};
          2'd1: rk1_d = rk1_q ^ rk0_q;
          2'd2: rk2_d = rk2_q ^ rk1_q;
          2'd3: begin
            rk3_d   = rk3_q ^ rk2_q;
            round_d = round_q + 4'd1;
            rcon_d  = xtime(rcon_q);
            state_d = S_PRESENT;
          end
        endcase
        j_d = j_q + 2'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rk0_q   <= '0;
      rk1_q   <= '0;
      rk2_q   <= '0;
      rk3_q   <= '0;
      rcon_q  <= 8'h01;
      j_q     <= 2'd0;
      round_q <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk0_q   <= rk0_d;
      rk1_q   <= rk1_d;
      rk2_q   <= rk2_d;
      rk3_q   <= rk3_d;
      rcon_q  <= rcon_d;
      j_q     <= j_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign rk_valid  = (state_q == S_PRESENT);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign round_key = {rk0_q, rk1_q, rk2_q, rk3_q};
  assign round_idx = round_q;

endmodule
